// File: rtl/elevator_timer_if.sv
// Control/status bundle between the elevator controller FSM and one timer.
interface elevator_timer_if #(
   parameter int unsigned SEC_W = 4
);
   logic             start;
   logic             pause;
   logic             clear;
   logic [SEC_W-1:0] limit;
   logic [SEC_W-1:0] timeout;
   logic             tick;
   logic             expired;
   logic             running;
   logic             done_reset;

   modport master (
      output start, pause, clear, limit,
      input  timeout, tick, expired, running, done_reset
   );

   modport slave (
      input  start, pause, clear, limit,
      output timeout, tick, expired, running, done_reset
   );
endinterface

// File: rtl/elevator_timer.sv
// Prescaled step timer with start/pause/clear, programmable limit and
// one-shot or auto-reload expiry. All outputs are registered.
module elevator_timer #(
   parameter int unsigned CYCLES_PER_TICK = 100000000,
   parameter int unsigned SEC_W           = 4,
   parameter bit          AUTO_RELOAD     = 1'b0
) (
   input logic             clk,
   input logic             reseta,
   elevator_timer_if.slave bus
);
   localparam int unsigned     PW         = $clog2(CYCLES_PER_TICK);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(CYCLES_PER_TICK - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      EXPIRED
   } state_t;

   state_t           state_q;
   logic [PW-1:0]    presc_q;
   logic [SEC_W-1:0] count_q;
   logic [SEC_W-1:0] limit_q;
   logic             tick_q;
   logic             expired_q;
   logic             running_q;
   logic             done_reset_q;
   logic [SEC_W-1:0] next_count;

   // Candidate step value; wraps naturally at 2^SEC_W.
   always_comb begin
      next_count = count_q + SEC_W'(1);
   end

   // Control FSM, prescaler, step counter and registered pulses.
   // running is written alongside every state change so it equals (state==RUN)
   // in the same cycle without a combinational decode.
   always_ff @(posedge clk) begin
      tick_q       <= 1'b0;
      expired_q    <= 1'b0;
      done_reset_q <= 1'b0;
      if (reseta) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         count_q      <= '0;
         limit_q      <= '0;
         running_q    <= 1'b0;
         done_reset_q <= 1'b1;
      end else if (bus.clear) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         count_q   <= '0;
         running_q <= 1'b0;
      end else if (bus.start) begin
         state_q   <= RUN;
         presc_q   <= '0;
         count_q   <= '0;
         limit_q   <= bus.limit;
         running_q <= 1'b1;
      end else if (state_q == RUN || state_q == PAUSED) begin
         if (bus.pause) begin
            state_q   <= PAUSED;
            running_q <= 1'b0;
         end else begin
            state_q   <= RUN;
            running_q <= 1'b1;
            if (presc_q != PRESC_LAST) begin
               presc_q <= presc_q + PW'(1);
            end else begin
               presc_q <= '0;
               tick_q  <= 1'b1;
               if (limit_q != '0 && next_count == limit_q) begin
                  expired_q <= 1'b1;
                  if (AUTO_RELOAD) begin
                     count_q <= '0;
                  end else begin
                     count_q   <= limit_q;
                     state_q   <= EXPIRED;
                     running_q <= 1'b0;
                  end
               end else begin
                  count_q <= next_count;
               end
            end
         end
      end
   end

   assign bus.timeout    = count_q;
   assign bus.tick       = tick_q;
   assign bus.expired    = expired_q;
   assign bus.running    = running_q;
   assign bus.done_reset = done_reset_q;
endmodule

// File: tb/tb_elevator_timer.sv
// Randomized check of a one-shot and an auto-reload timer driven in parallel,
// against a model that counts elapsed active cycles since start.
module tb_elevator_timer;
   localparam int unsigned CPT = 4;
   localparam int unsigned SW  = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

   logic          clk = 1'b0;
   logic          reseta, start, pause, clear;
   logic [SW-1:0] limit;

   elevator_timer_if #(.SEC_W(SW)) bus_os ();
   elevator_timer_if #(.SEC_W(SW)) bus_ar ();

   assign bus_os.start = start;
   assign bus_os.pause = pause;
   assign bus_os.clear = clear;
   assign bus_os.limit = limit;
   assign bus_ar.start = start;
   assign bus_ar.pause = pause;
   assign bus_ar.clear = clear;
   assign bus_ar.limit = limit;

   elevator_timer #(.CYCLES_PER_TICK(CPT), .SEC_W(SW), .AUTO_RELOAD(1'b0)) dut_os (
      .clk(clk), .reseta(reseta), .bus(bus_os)
   );
   elevator_timer #(.CYCLES_PER_TICK(CPT), .SEC_W(SW), .AUTO_RELOAD(1'b1)) dut_ar (
      .clk(clk), .reseta(reseta), .bus(bus_ar)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mode  [2];
   int unsigned act   [2];
   int unsigned limq  [2];
   int unsigned e_to  [2];
   int unsigned e_tick[2];
   int unsigned e_exp [2];
   int unsigned e_run [2];
   int unsigned e_done[2];

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Model: instance m reloads when m==1. Time is tracked as the number of
   // counting edges since start; steps and the visible count derive from it.
   function automatic void model_step(input int m);
      int unsigned steps;
      e_tick[m] = 0;
      e_exp[m]  = 0;
      e_done[m] = reseta ? 1 : 0;
      if (reseta) begin
         mode[m] = M_IDLE; act[m] = 0; limq[m] = 0; e_to[m] = 0;
      end else if (clear) begin
         mode[m] = M_IDLE; act[m] = 0; e_to[m] = 0;
      end else if (start) begin
         mode[m] = M_RUN; act[m] = 0; e_to[m] = 0; limq[m] = limit;
      end else if (mode[m] == M_RUN || mode[m] == M_PAUSED) begin
         if (pause) begin
            mode[m] = M_PAUSED;
         end else begin
            mode[m] = M_RUN;
            act[m]++;
            if (act[m] % CPT == 0) begin
               e_tick[m] = 1;
               steps = act[m] / CPT;
               if (limq[m] == 0) begin
                  e_to[m] = steps % (1 << SW);
               end else if (m == 1) begin
                  e_to[m] = steps % limq[m];
                  if (e_to[m] == 0) e_exp[m] = 1;
               end else if (steps == limq[m]) begin
                  e_exp[m] = 1;
                  e_to[m]  = limq[m];
                  mode[m]  = M_EXP;
               end else begin
                  e_to[m] = steps;
               end
            end
         end
      end
      e_run[m] = (mode[m] == M_RUN) ? 1 : 0;
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_eq("os.timeout",    bus_os.timeout,    e_to[0]);
      check_eq("os.tick",       bus_os.tick,       e_tick[0]);
      check_eq("os.expired",    bus_os.expired,    e_exp[0]);
      check_eq("os.running",    bus_os.running,    e_run[0]);
      check_eq("os.done_reset", bus_os.done_reset, e_done[0]);
      check_eq("ar.timeout",    bus_ar.timeout,    e_to[1]);
      check_eq("ar.tick",       bus_ar.tick,       e_tick[1]);
      check_eq("ar.expired",    bus_ar.expired,    e_exp[1]);
      check_eq("ar.running",    bus_ar.running,    e_run[1]);
      check_eq("ar.done_reset", bus_ar.done_reset, e_done[1]);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_start(input logic [SW-1:0] l);
      limit = l;
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   initial begin
      reseta = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; limit = '0;
      for (int m = 0; m < 2; m++) begin
         mode[m] = M_IDLE; act[m] = 0; limq[m] = 0; e_to[m] = 0;
      end
      run(2);
      reseta = 1'b0;
      run(2);

      // one-shot limit 3 (reload instance sees limit 3 too)
      do_start(4'd3);
      run(32);
      // limit 2: reload expiries every 8 cycles
      do_start(4'd2);
      run(30);
      // free-running wrap past 15
      do_start(4'd0);
      run(72);
      // pause for 7 cycles when prescaler is at its last value, timeout=1
      do_start(4'd5);
      run(7);
      pause = 1'b1;
      run(7);
      pause = 1'b0;
      run(24);
      // start and clear together
      limit = 4'd3; start = 1'b1; clear = 1'b1;
      cycle();
      start = 1'b0; clear = 1'b0;
      run(4);
      // start on the edge that would expire
      do_start(4'd2);
      run(7);
      do_start(4'd2);
      run(6);
      // reset mid-count at timeout=2
      do_start(4'd5);
      run(9);
      reseta = 1'b1;
      cycle();
      reseta = 1'b0;
      run(4);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         reseta = ($urandom % 300) == 0;
         clear  = ($urandom % 80) == 0;
         start  = ($urandom % 30) == 0;
         if (($urandom % 12) == 0) pause = ~pause;
         limit  = (($urandom % 4) == 0) ? '0 : SW'($urandom_range(1, 5));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
